// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad operand loader: FSM states, special key codes
// and the BCD-to-binary conversion used when an operand is committed.
package keypad_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    // Largest supported entry; narrower entries are zero-extended before conversion.
    localparam int MAX_DIGITS = 4;
    localparam int MAX_BIN_W  = 14;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    // Horner evaluation, most significant digit first; unused upper digits are zero.
    function automatic logic [MAX_BIN_W-1:0] bcd_to_bin(input logic [4*MAX_DIGITS-1:0] bcd);
        logic [MAX_BIN_W-1:0] acc;
        acc = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            acc = MAX_BIN_W'(acc * MAX_BIN_W'(10)) + MAX_BIN_W'(bcd[4*i +: 4]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Rising-edge detector for the debounced key level. The history flop resets high so a key
// already held when reset is released is not reported as a new press.
module key_edge_detect (
    input  logic clk,
    input  logic n_reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/keypad_operand_loader.sv
// Collects two decimal operands from keypad presses and offers them over valid/ready.
// Define BACKSPACE_EN to make key 0xB delete the most recently typed digit.
module keypad_operand_loader
    import keypad_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int OP_W   = 8
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic [OP_W-1:0]       op_a,
    output logic [OP_W-1:0]       op_b,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [4*DIGITS-1:0]   entry_bcd,
    output logic [2:0]            digit_cnt,
    output logic                  phase_b,
    output logic                  overflow
);

    localparam int EW = 4 * DIGITS;

`ifdef BACKSPACE_EN
    localparam bit BKSP_EN = 1'b1;
`else
    localparam bit BKSP_EN = 1'b0;
`endif

    logic                 press;
    state_t               state_q;
    logic [OP_W-1:0]      op_a_q;
    logic [OP_W-1:0]      op_b_q;
    logic                 op_valid_q;
    logic [EW-1:0]        entry_q;
    logic [2:0]           digit_cnt_q;
    logic                 phase_b_q;
    logic                 overflow_q;

    logic [EW+3:0]        entry_shift_d;
    logic [EW-1:0]        entry_push_d;
    logic [4*MAX_DIGITS-1:0] entry_wide_d;
    logic [MAX_BIN_W-1:0] entry_bin_d;
    logic [OP_W-1:0]      entry_val_d;
    logic                 entry_full_d;

    key_edge_detect u_edge (
        .clk     (clk),
        .n_reset (n_reset),
        .level   (key_valid),
        .rise    (press)
    );

    // New digit enters at the least significant position, older digits move up.
    assign entry_shift_d = {entry_q, key_code};
    assign entry_push_d  = entry_shift_d[EW-1:0];
    assign entry_wide_d  = (4*MAX_DIGITS)'(entry_q);
    assign entry_bin_d   = bcd_to_bin(entry_wide_d);
    assign entry_val_d   = OP_W'(entry_bin_d);
    assign entry_full_d  = (digit_cnt_q >= 3'(DIGITS));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_A;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_valid_q  <= 1'b0;
            entry_q     <= '0;
            digit_cnt_q <= 3'd0;
            phase_b_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            case (state_q)
                S_A, S_B: begin
                    if (press) begin
                        if (is_digit(key_code)) begin
                            if (entry_full_d) begin
                                overflow_q <= 1'b1;
                            end else begin
                                entry_q     <= entry_push_d;
                                digit_cnt_q <= digit_cnt_q + 3'd1;
                            end
                        end else if (key_code == KEY_ENTER) begin
                            // An empty entry is not committed as a zero operand.
                            if (digit_cnt_q != 3'd0) begin
                                entry_q     <= '0;
                                digit_cnt_q <= 3'd0;
                                if (state_q == S_A) begin
                                    op_a_q    <= entry_val_d;
                                    state_q   <= S_B;
                                    phase_b_q <= 1'b1;
                                end else begin
                                    op_b_q     <= entry_val_d;
                                    state_q    <= S_WAIT;
                                    op_valid_q <= 1'b1;
                                end
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            entry_q     <= '0;
                            digit_cnt_q <= 3'd0;
                            op_a_q      <= '0;
                            op_b_q      <= '0;
                            state_q     <= S_A;
                            phase_b_q   <= 1'b0;
                        end else if (BKSP_EN && (key_code == KEY_BKSP)) begin
                            if (digit_cnt_q != 3'd0) begin
                                entry_q     <= entry_q >> 4;
                                digit_cnt_q <= digit_cnt_q - 3'd1;
                            end
                        end
                    end
                end
                S_WAIT: begin
                    // Keys are deliberately ignored here so the offered operands stay stable.
                    if (op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= S_A;
                        phase_b_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_A;
                end
            endcase
        end
    end

    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_valid  = op_valid_q;
    assign entry_bcd = entry_q;
    assign digit_cnt = digit_cnt_q;
    assign phase_b   = phase_b_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_operand_loader.sv
// Directed plus randomized bench for keypad_operand_loader, checked against a digit-queue
// model of operand entry. Honours BACKSPACE_EN the same way the design does.
module tb_keypad_operand_loader;

    localparam int DIGITS = 2;
    localparam int OP_W   = 8;

    logic                clk = 1'b0;
    logic                n_reset = 1'b0;
    logic                key_valid = 1'b0;
    logic [3:0]          key_code = 4'd0;
    logic                op_ready = 1'b0;
    logic [OP_W-1:0]     op_a;
    logic [OP_W-1:0]     op_b;
    logic                op_valid;
    logic [4*DIGITS-1:0] entry_bcd;
    logic [2:0]          digit_cnt;
    logic                phase_b;
    logic                overflow;

    keypad_operand_loader #(.DIGITS(DIGITS), .OP_W(OP_W)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .entry_bcd (entry_bcd),
        .digit_cnt (digit_cnt),
        .phase_b   (phase_b),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = typing A, 1 = typing B, 2 = waiting for acceptance.
    int m_phase;
    int m_dig[$];
    int m_a;
    int m_b;
    bit m_valid;
    bit m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_bcd();
        int b = 0;
        foreach (m_dig[i]) b = (b << 4) | m_dig[i];
        return b;
    endfunction

    function automatic int exp_val();
        int v = 0;
        foreach (m_dig[i]) v = v * 10 + m_dig[i];
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_dig.delete();
        m_a = 0;
        m_b = 0;
        m_valid = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic model_key(input int code);
        if (m_phase == 2) return;
        if (code <= 9) begin
            if (m_dig.size() < DIGITS) m_dig.push_back(code);
            else m_ovf = 1'b1;
        end else if (code == 10) begin
            if (m_dig.size() > 0) begin
                if (m_phase == 0) begin
                    m_a = exp_val();
                    m_phase = 1;
                end else begin
                    m_b = exp_val();
                    m_phase = 2;
                    m_valid = 1'b1;
                end
                m_dig.delete();
            end
        end else if (code == 12) begin
            m_dig.delete();
            m_a = 0;
            m_b = 0;
            m_phase = 0;
        end else if (code == 11) begin
`ifdef BACKSPACE_EN
            if (m_dig.size() > 0) void'(m_dig.pop_back());
`endif
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_op_a"}, 32'(op_a), 32'(m_a));
        chk({tag, "_op_b"}, 32'(op_b), 32'(m_b));
        chk({tag, "_op_valid"}, 32'(op_valid), 32'(m_valid));
        chk({tag, "_entry_bcd"}, 32'(entry_bcd), 32'(exp_bcd()));
        chk({tag, "_digit_cnt"}, 32'(digit_cnt), 32'(m_dig.size()));
        chk({tag, "_phase_b"}, 32'(phase_b), 32'(m_phase != 0));
        chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic press(input logic [3:0] code, input int hold);
        key_code  = code;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        m_ovf = 1'b0;
        model_key(int'(code));
        check_all("press");
        $display("key %h: op_a=%0d op_b=%0d valid=%0b entry=%h cnt=%0d phase_b=%0b ovf=%0b",
                 code, op_a, op_b, op_valid, entry_bcd, digit_cnt, phase_b, overflow);
        if (hold > 1) begin
            repeat (hold - 1) @(posedge clk);
            #1;
            m_ovf = 1'b0;
            check_all("hold");
        end
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        m_ovf = 1'b0;
        check_all("release");
    endtask

    task automatic accept(input bit with_key, input logic [3:0] code);
        op_ready = 1'b1;
        if (with_key) begin
            key_code  = code;
            key_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        m_ovf = 1'b0;
        if (m_phase == 2) begin
            m_valid = 1'b0;
            m_phase = 0;
        end else if (with_key) begin
            model_key(int'(code));
        end
        check_all("accept");
        $display("ready with_key=%0b key=%h: op_a=%0d op_b=%0d valid=%0b phase_b=%0b",
                 with_key, code, op_a, op_b, op_valid, phase_b);
        op_ready  = 1'b0;
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        m_ovf = 1'b0;
        check_all("post_accept");
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        $display("async reset (%s): op_a=%0d valid=%0b cnt=%0d", tag, op_a, op_valid, digit_cnt);
        @(negedge clk);
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        check_all({tag, "_released"});
    endtask

    initial begin
        model_reset();
        // Key held across reset release must not count as a press.
        key_code  = 4'd5;
        key_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("held_thru_reset");
        key_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("held_thru_reset_rel");

        // Two operands with the consumer stalled.
        press(4'd4, 1); press(4'd2, 1); press(4'hA, 1);
        press(4'd1, 1); press(4'd7, 1); press(4'hA, 1);
        chk("t1_op_a", 32'(op_a), 32'd42);
        chk("t1_op_b", 32'(op_b), 32'd17);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("t1_valid_held", 32'(op_valid), 32'd1);
        end

        accept(1'b0, 4'd0);
        chk("t2_valid", 32'(op_valid), 32'd0);
        chk("t2_phase", 32'(phase_b), 32'd0);
        chk("t2_op_a", 32'(op_a), 32'd42);

        // Third digit overflows the entry.
        press(4'd1, 1); press(4'd2, 1); press(4'd3, 1);
        chk("t3_entry", 32'(entry_bcd), 32'h12);
        chk("t3_cnt", 32'(digit_cnt), 32'd2);
        press(4'hA, 1);
        chk("t3_op_a", 32'(op_a), 32'd12);

        press(4'd5, 1); press(4'hC, 1);
        chk("t4_phase", 32'(phase_b), 32'd0);
        chk("t4_op_a", 32'(op_a), 32'd0);
        press(4'hA, 1);
        chk("t4_empty_enter_phase", 32'(phase_b), 32'd0);

        press(4'd3, 100);
        chk("t5_hold_cnt", 32'(digit_cnt), 32'd1);
        press(4'hC, 1);
        press(4'd1, 1); press(4'hA, 1); press(4'd2, 1); press(4'hA, 1);
        press(4'd5, 1); press(4'hC, 1); press(4'hA, 1);
        chk("t5_wait_valid", 32'(op_valid), 32'd1);
        chk("t5_wait_op_b", 32'(op_b), 32'd2);
        accept(1'b1, 4'd9);
        chk("t5_accept_drop", 32'(digit_cnt), 32'd0);

        press(4'd7, 1); press(4'd8, 1); press(4'hB, 1);
`ifdef BACKSPACE_EN
        chk("t6_entry", 32'(entry_bcd), 32'h07);
        chk("t6_cnt", 32'(digit_cnt), 32'd1);
        press(4'hB, 1); press(4'hB, 1);
        chk("t6_empty_bksp", 32'(digit_cnt), 32'd0);
`else
        chk("t6_entry", 32'(entry_bcd), 32'h78);
        chk("t6_cnt", 32'(digit_cnt), 32'd2);
`endif
        async_reset("rst_mid_entry");
        press(4'd9, 1); press(4'hA, 1); press(4'd9, 1); press(4'd9, 1); press(4'hA, 1);
        chk("max_op_b", 32'(op_b), 32'd99);
        async_reset("rst_mid_handshake");

        for (int i = 0; i < 300; i++) begin
            int r;
            logic [3:0] code;
            r = $urandom_range(0, 9);
            if (r < 5) code = 4'($urandom_range(0, 9));
            else if (r < 7) code = 4'hA;
            else code = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 4) == 0) accept(1'($urandom_range(0, 1)), code);
            else press(code, int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
